token_run_encoder: RTL

- Downstream stage of the token doubler. Consumes its serial token output stream, one bit per clock.
- Measures the length of each run of consecutive '1' tokens and emits each completed run length as a word over a valid/ready interface.
- Contains a small first-word-fall-through FIFO that absorbs back-pressure from the word-oriented consumer.

---
 rtl/token_run_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/token_run_encoder.sv
// Run-length encoder for a serial token stream. Each completed run of '1's becomes
// one {len, sat, kind} entry in a small FWFT FIFO. Zero runs are also encoded when
// TOKEN_RUN_ZERO_RUNS_EN is defined.
module token_run_encoder #(
  parameter int CNT_W      = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_len,
  output logic             out_sat,
  output logic             out_kind,
  output logic             drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             sat_inc;

  logic             push_req;
  logic             push_kind;

  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W+1:0] mem_q [FIFO_DEPTH];
  logic [CNT_W+1:0] head;
  logic             empty, full, pop, push_ok, push_lost;
  logic             drop_q;

  // Counter saturates at CNT_MAX; sat latches the moment the max is reached.
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
  assign sat_inc = sat_q | (cnt_inc == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (in_bit) begin
          state_d = S_RUN;
          cnt_d   = CNT_ONE;
          sat_d   = (CNT_ONE == CNT_MAX);
        end else begin
`ifdef TOKEN_RUN_ZERO_RUNS_EN
          cnt_d = cnt_inc;
          sat_d = sat_inc;
`else
          cnt_d = '0;
          sat_d = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (in_bit) begin
          cnt_d = cnt_inc;
          sat_d = sat_inc;
        end else begin
          state_d = S_IDLE;
`ifdef TOKEN_RUN_ZERO_RUNS_EN
          cnt_d = CNT_ONE;
          sat_d = (CNT_ONE == CNT_MAX);
`else
          cnt_d = '0;
          sat_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A run is pushed on the edge that samples the bit ending it.
  always_comb begin
    push_req  = 1'b0;
    push_kind = 1'b1;
    case (state_q)
      S_IDLE: begin
`ifdef TOKEN_RUN_ZERO_RUNS_EN
        if (in_bit && (cnt_q != '0)) begin
          push_req  = 1'b1;
          push_kind = 1'b0;
        end
`endif
      end
      S_RUN:   push_req = !in_bit;
      default: push_req = 1'b0;
    endcase
  end

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop       = !empty && out_ready;
  assign push_ok   = push_req && (!full || pop);
  assign push_lost = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push_ok)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_lost) drop_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= {push_kind, sat_q, cnt_q};
  end

  // Outputs are forced to zero while the FIFO is empty.
  assign head      = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign out_valid = !empty;
  assign out_len   = out_valid ? head[CNT_W-1:0] : '0;
  assign out_sat   = out_valid & head[CNT_W];
  assign out_kind  = out_valid & head[CNT_W+1];
  assign drop      = drop_q;

endmodule
